divergence_logger: RTL and testbench
====================================

DIVERGENCE_LOGGER -- requirements
Module: divergence_logger

Interface
REQ-001 SHALL have parameter WIDTH, default 32, the per-channel compared data width.
REQ-002 SHALL have parameter CHANNELS, default 4, the number of compared channels (1..256).
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, the log FIFO entries (power of two, >=2).
REQ-004 SHALL have ports, with clock and reset first: clock in 1, the single clock; reset in 1, synchronous active-high reset.
REQ-005 SHALL have port enable in 1, designs-running qualifier.
REQ-006 SHALL have port cycle_number in 48, free-running cycle count.
REQ-007 SHALL have port real_data in CHANNELS*WIDTH, golden outputs, channel c at [c*WIDTH +: WIDTH].
REQ-008 SHALL have port inj_data in CHANNELS*WIDTH, fault-injected outputs, same packing.
REQ-009 SHALL have ports log_valid out 1, log_ready in 1, log_data out 40+WIDTH, with log_data = {cycle[31:0], channel[7:0], xor[WIDTH-1:0]}.
REQ-010 SHALL have port clear_stats in 1, clearing the statistics and the first-divergence latch.
REQ-011 SHALL have ports mismatch_cycles out 32, drop_count out 32, first_valid out 1, first_cycle out 48, first_channel out 8.

Function
REQ-012 SHALL register real_data, inj_data, cycle_number and enable (armed) every edge; compare stage uses only registered values.
REQ-013 SHALL form mask[c] = armed and (real_r[c] != inj_r[c]); no mismatch is reported in the cycle after enable first rises.
REQ-014 SHALL run FSM IDLE/SCAN: in IDLE, a nonzero mask loads snapshot (mask, per-channel XOR, cycle_r) and the FSM moves to SCAN.
REQ-015 SHALL, in SCAN, push one entry per cycle for the lowest set snapshot channel when the FIFO is not full, then clear that bit; return to IDLE on the edge that clears the last bit.
REQ-016 SHALL stall SCAN without loss while the FIFO is full.
REQ-017 SHALL increment drop_count (saturating at 2^32-1) once per cycle in which the mask is nonzero and the FSM is not IDLE.
REQ-018 SHALL increment mismatch_cycles (saturating) once per cycle with nonzero mask, whether captured or dropped.
REQ-019 SHALL on the first nonzero mask since reset/clear set first_valid=1, first_cycle=cycle_r, first_channel=lowest set index; hold thereafter.
REQ-020 SHALL give latency: inputs sampled at edge k appear at the FIFO head (log_valid=1) after edge k+2 for the first channel.
REQ-021 SHALL be a show-ahead FIFO; pop when log_valid and log_ready; simultaneous push and pop when full is allowed only if the pop frees the slot in the same edge.
REQ-022 SHALL keep log_data stable while log_valid=1 and log_ready=0.
REQ-023 SHALL give clear_stats priority: in a clear cycle, counters and first_* go to 0 and that cycle's mismatch is neither counted nor latched; FIFO and FSM unaffected.
REQ-024 SHALL wrap FIFO pointers modulo FIFO_DEPTH using an extra bit for full/empty.

Reset
REQ-025 SHALL on reset set log_valid=0, mismatch_cycles=0, drop_count=0, first_valid=0, first_cycle=0, first_channel=0, FSM=IDLE, FIFO empty, armed=0, all pipeline registers 0.
REQ-026 SHALL let reset mid-SCAN discard the snapshot and FIFO contents in the same edge.
REQ-027 SHALL leave log_data undefined-free (0) when log_valid=0.

Configuration
REQ-028 SHALL, with DIVERGENCE_LOGGER_MASK_EN defined, add input chan_mask (CHANNELS bits, registered with the data); a channel with chan_mask=1 never sets mask[c].
REQ-029 SHALL, without DIVERGENCE_LOGGER_MASK_EN, have no chan_mask port and compare all channels.

Verification
REQ-030 SHALL cover: CHANNELS=4, channel 2 inj=real^0x10 at cycle 100, log_ready=1 -> one entry {100, 2, 0x00000010}, mismatch_cycles=1, first_channel=2.
REQ-031 SHALL cover: channels 0,1,3 mismatch in cycle 50 -> entries in order ch0, ch1, ch3 on consecutive cycles, all with cycle 50.
REQ-032 SHALL cover: channels 0-3 mismatch at cycle 10 and channel 1 at cycle 11 -> drop_count=1, mismatch_cycles=2.
REQ-033 SHALL cover: FIFO_DEPTH=4, log_ready=0, 6 single mismatches -> 4 entries then stall/drops; raising log_ready drains in cycle order with no duplicates.
REQ-034 SHALL cover: clear_stats coincident with a mismatch -> counters 0, first_valid=0, entry still logged.
REQ-035 SHALL cover: MASK_EN with chan_mask=4'b0100 and channel 2 mismatching -> no entry, mismatch_cycles=0.

Source files
------------

// File: rtl/divergence_logger.sv
// divergence_logger: compares golden and fault-injected channel outputs,
// captures the per-channel differences of a divergent cycle in a snapshot,
// serialises them into a show-ahead log FIFO (lowest channel first) and keeps
// mismatch/drop statistics plus a latch of the first divergence.
// Optional feature: define DIVERGENCE_LOGGER_MASK_EN to add the chan_mask
// input; masked channels never report a mismatch.
//
// Handshake: an entry transfers on every rising clock edge where
// log_valid && log_ready; log_data is held stable while log_valid && !log_ready,
// and reads as zero whenever log_valid is low.
module divergence_logger #(
  parameter int WIDTH      = 32,
  parameter int CHANNELS   = 4,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         enable,
  input  logic [47:0]                  cycle_number,
  input  logic [CHANNELS*WIDTH-1:0]    real_data,
  input  logic [CHANNELS*WIDTH-1:0]    inj_data,
`ifdef DIVERGENCE_LOGGER_MASK_EN
  input  logic [CHANNELS-1:0]          chan_mask,
`endif
  output logic                         log_valid,
  input  logic                         log_ready,
  output logic [40+WIDTH-1:0]          log_data,
  input  logic                         clear_stats,
  output logic [31:0]                  mismatch_cycles,
  output logic [31:0]                  drop_count,
  output logic                         first_valid,
  output logic [47:0]                  first_cycle,
  output logic [7:0]                   first_channel,
  output logic                         dbg_state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = 40 + WIDTH;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  // input capture stage
  logic [CHANNELS*WIDTH-1:0] real_r;
  logic [CHANNELS*WIDTH-1:0] inj_r;
  logic [47:0]               cycle_r;
  logic                      armed;
  logic [CHANNELS-1:0]       ignore_r;

  // compare stage
  logic [CHANNELS-1:0]       mask;
  logic [CHANNELS*WIDTH-1:0] xor_vec;
  logic                      mask_any;
  logic [7:0]                mask_low;

  // snapshot being serialised
  logic [CHANNELS-1:0]       snap_mask;
  logic [CHANNELS*WIDTH-1:0] snap_xor;
  logic [31:0]               snap_cycle;
  logic [CHANNELS-1:0]       snap_rest;
  logic [7:0]                scan_idx;
  logic [WIDTH-1:0]          scan_xor;

  // fsm
  state_t state, state_nx;
  logic   load, push, busy_drop;

  // fifo
  logic [LW-1:0] mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          empty, full, pop, fifo_ok;
  logic [LW-1:0] push_entry;

  // Register all compared inputs so the compare stage sees one coherent cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      real_r  <= '0;
      inj_r   <= '0;
      cycle_r <= '0;
      armed   <= 1'b0;
    end else begin
      real_r  <= real_data;
      inj_r   <= inj_data;
      cycle_r <= cycle_number;
      armed   <= enable;
    end
  end

`ifdef DIVERGENCE_LOGGER_MASK_EN
  // Channel ignore mask travels with the data it qualifies.
  always_ff @(posedge clock) begin
    if (reset) ignore_r <= '0;
    else       ignore_r <= chan_mask;
  end
`else
  assign ignore_r = '0;
`endif

  assign xor_vec  = real_r ^ inj_r;
  assign mask_any = |mask;

  // Per-channel mismatch flags and the lowest mismatching channel.
  always_comb begin
    mask     = '0;
    mask_low = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      mask[c] = armed && (xor_vec[c*WIDTH +: WIDTH] != '0) && !ignore_r[c];
    end
    for (int c = CHANNELS - 1; c >= 0; c--) begin
      if (mask[c]) mask_low = 8'(c);
    end
  end

  // Pick the lowest pending snapshot channel for the next log entry.
  always_comb begin
    scan_idx = '0;
    scan_xor = '0;
    for (int c = CHANNELS - 1; c >= 0; c--) begin
      if (snap_mask[c]) begin
        scan_idx = 8'(c);
        scan_xor = snap_xor[c*WIDTH +: WIDTH];
      end
    end
  end

  // Clearing the lowest set bit leaves the channels still to be logged.
  assign snap_rest  = snap_mask & (snap_mask - CHANNELS'(1));
  assign push_entry = {snap_cycle, scan_idx, scan_xor};

  // FIFO status; a full FIFO still accepts a push when the same edge pops.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop     = !empty && log_ready;
  assign fifo_ok = !full || pop;

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // FSM next state: leave SCAN on the push that drains the snapshot.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (mask_any) state_nx = SCAN;
      SCAN: if (fifo_ok && (snap_rest == '0)) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // FSM outputs: capture in IDLE, serialise in SCAN, drop divergences while busy.
  always_comb begin
    load      = (state == IDLE) && mask_any;
    push      = (state == SCAN) && fifo_ok;
    busy_drop = (state != IDLE) && mask_any;
  end

  assign dbg_state = state;

  // Snapshot capture and per-entry retirement.
  always_ff @(posedge clock) begin
    if (reset) begin
      snap_mask  <= '0;
      snap_xor   <= '0;
      snap_cycle <= '0;
    end else if (load) begin
      snap_mask  <= mask;
      snap_xor   <= xor_vec;
      snap_cycle <= cycle_r[31:0];
    end else if (push) begin
      snap_mask  <= snap_rest;
    end
  end

  // FIFO storage; contents are only meaningful between the pointers.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_entry;
  end

  // FIFO pointers with wrap bit for full/empty distinction.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  assign log_valid = !empty;
  assign log_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Statistics and first-divergence latch; clear_stats wins over counting.
  always_ff @(posedge clock) begin
    if (reset || clear_stats) begin
      mismatch_cycles <= '0;
      drop_count      <= '0;
      first_valid     <= 1'b0;
      first_cycle     <= '0;
      first_channel   <= '0;
    end else if (mask_any) begin
      if (mismatch_cycles != 32'hffff_ffff) mismatch_cycles <= mismatch_cycles + 1'b1;
      if (busy_drop && (drop_count != 32'hffff_ffff)) drop_count <= drop_count + 1'b1;
      if (!first_valid) begin
        first_valid   <= 1'b1;
        first_cycle   <= cycle_r;
        first_channel <= mask_low;
      end
    end
  end

endmodule

// File: tb/tb_divergence_logger.sv
// Testbench for divergence_logger: directed scenarios followed by random
// traffic, all checked against a queue-level reference model.
module tb_divergence_logger;

  localparam int WIDTH      = 32;
  localparam int CHANNELS   = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int LW         = 40 + WIDTH;

  logic                      clock;
  logic                      reset;
  logic                      enable;
  logic [47:0]               cycle_number;
  logic [CHANNELS*WIDTH-1:0] real_data;
  logic [CHANNELS*WIDTH-1:0] inj_data;
  logic [CHANNELS-1:0]       chan_mask;
  logic                      log_valid;
  logic                      log_ready;
  logic [LW-1:0]             log_data;
  logic                      clear_stats;
  logic [31:0]               mismatch_cycles;
  logic [31:0]               drop_count;
  logic                      first_valid;
  logic [47:0]               first_cycle;
  logic [7:0]                first_channel;
  logic                      dbg_state;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [LW-1:0]             exp_q[$];   // expected FIFO contents, head first
  logic [LW-1:0]             pend_q[$];  // captured entries not yet in the FIFO
  logic [CHANNELS-1:0]       m_mask;
  logic [CHANNELS*WIDTH-1:0] m_xor;
  logic [47:0]               m_cyc;
  logic [31:0]               m_mis;
  logic [31:0]               m_drop;
  logic                      m_fv;
  logic [47:0]               m_fc;
  logic [7:0]                m_fch;

  divergence_logger #(
    .WIDTH(WIDTH), .CHANNELS(CHANNELS), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clock(clock),
    .reset(reset),
    .enable(enable),
    .cycle_number(cycle_number),
    .real_data(real_data),
    .inj_data(inj_data),
`ifdef DIVERGENCE_LOGGER_MASK_EN
    .chan_mask(chan_mask),
`endif
    .log_valid(log_valid),
    .log_ready(log_ready),
    .log_data(log_data),
    .clear_stats(clear_stats),
    .mismatch_cycles(mismatch_cycles),
    .drop_count(drop_count),
    .first_valid(first_valid),
    .first_cycle(first_cycle),
    .first_channel(first_channel),
    .dbg_state(dbg_state)
  );

  // clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // safety net against a stuck run
  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, observed time %0t required < 200000", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Compare every DUT output with the model.
  task automatic check_outputs();
    logic [LW-1:0] head;
    head = (exp_q.size() != 0) ? exp_q[0] : '0;
    chk("log_valid", 128'(log_valid), 128'(exp_q.size() != 0));
    chk("log_data", 128'(log_data), 128'(head));
    chk("mismatch_cycles", 128'(mismatch_cycles), 128'(m_mis));
    chk("drop_count", 128'(drop_count), 128'(m_drop));
    chk("first_valid", 128'(first_valid), 128'(m_fv));
    chk("first_cycle", 128'(first_cycle), 128'(m_fc));
    chk("first_channel", 128'(first_channel), 128'(m_fch));
    chk("busy_state", 128'(dbg_state), 128'(pend_q.size() != 0));
  endtask

  // Advance the model by one clock edge using the inputs seen at that edge.
  task automatic model_edge();
    logic busy;
    logic found;
    if (reset) begin
      exp_q.delete();
      pend_q.delete();
      m_mask = '0; m_xor = '0; m_cyc = '0;
      m_mis = '0; m_drop = '0; m_fv = 1'b0; m_fc = '0; m_fch = '0;
      return;
    end
    busy = (pend_q.size() != 0);
    if ((exp_q.size() != 0) && log_ready) void'(exp_q.pop_front());
    if (busy) begin
      if (exp_q.size() < FIFO_DEPTH) exp_q.push_back(pend_q.pop_front());
    end else if (m_mask != '0) begin
      for (int c = 0; c < CHANNELS; c++)
        if (m_mask[c]) pend_q.push_back({m_cyc[31:0], 8'(c), m_xor[c*WIDTH +: WIDTH]});
    end
    if (clear_stats) begin
      m_mis = '0; m_drop = '0; m_fv = 1'b0; m_fc = '0; m_fch = '0;
    end else if (m_mask != '0) begin
      if (m_mis != 32'hffff_ffff) m_mis = m_mis + 1;
      if (busy && (m_drop != 32'hffff_ffff)) m_drop = m_drop + 1;
      if (!m_fv) begin
        m_fv = 1'b1;
        m_fc = m_cyc;
        found = 1'b0;
        for (int c = 0; c < CHANNELS; c++)
          if (m_mask[c] && !found) begin found = 1'b1; m_fch = 8'(c); end
      end
    end
    m_xor = real_data ^ inj_data;
    m_cyc = cycle_number;
    for (int c = 0; c < CHANNELS; c++)
      m_mask[c] = enable && (m_xor[c*WIDTH +: WIDTH] != '0)
`ifdef DIVERGENCE_LOGGER_MASK_EN
                  && !chan_mask[c]
`endif
                  ;
  endtask

  // One clock: check outputs mid-cycle, step model at the edge, then move on.
  task automatic tick();
    @(negedge clock);
    check_outputs();
    @(posedge clock);
    model_edge();
    #1;
    cycle_number = cycle_number + 48'd1;
  endtask

  task automatic drive_clean();
    for (int c = 0; c < CHANNELS; c++) real_data[c*WIDTH +: WIDTH] = $urandom;
    inj_data = real_data;
  endtask

  task automatic drive_mismatch(input logic [CHANNELS-1:0] chs, input logic [WIDTH-1:0] x);
    drive_clean();
    for (int c = 0; c < CHANNELS; c++)
      if (chs[c]) inj_data[c*WIDTH +: WIDTH] = inj_data[c*WIDTH +: WIDTH] ^ x;
  endtask

  initial begin
    drive_clean();
    enable = 1'b0; log_ready = 1'b1; clear_stats = 1'b0; reset = 1'b1;
    cycle_number = '0; chan_mask = '0;
    tick(); tick();

    // reset state
    chk("rst_log_valid", 128'(log_valid), 128'(0));
    chk("rst_log_data", 128'(log_data), 128'(0));
    chk("rst_mismatch", 128'(mismatch_cycles), 128'(0));
    chk("rst_drop", 128'(drop_count), 128'(0));
    chk("rst_first_valid", 128'(first_valid), 128'(0));
    chk("rst_state", 128'(dbg_state), 128'(0));

    reset = 1'b0; enable = 1'b1;
    repeat (3) tick();

    // single channel divergence at cycle 100
    cycle_number = 48'd100;
    drive_mismatch(4'b0100, 32'h10);
    tick();
    drive_clean();
    tick(); tick();
    chk("s1_valid", 128'(log_valid), 128'(1));
    chk("s1_entry", 128'(log_data), 128'({32'd100, 8'd2, 32'h10}));
    chk("s1_mismatch", 128'(mismatch_cycles), 128'(1));
    chk("s1_first_channel", 128'(first_channel), 128'(2));
    chk("s1_first_cycle", 128'(first_cycle), 128'(100));
    tick();
    chk("s1_drained", 128'(log_valid), 128'(0));

    // three channels in one cycle come out lowest first on consecutive cycles
    tick();
    cycle_number = 48'd50;
    drive_mismatch(4'b1011, 32'h0000_0a5a);
    tick();
    drive_clean();
    tick(); tick();
    chk("s2_ch0", 128'(log_data), 128'({32'd50, 8'd0, 32'h0000_0a5a}));
    tick();
    chk("s2_ch1", 128'(log_data), 128'({32'd50, 8'd1, 32'h0000_0a5a}));
    tick();
    chk("s2_ch3", 128'(log_data), 128'({32'd50, 8'd3, 32'h0000_0a5a}));
    tick();
    chk("s2_drained", 128'(log_valid), 128'(0));

    // divergence while the scanner is busy is dropped
    clear_stats = 1'b1;
    tick();
    clear_stats = 1'b0;
    cycle_number = 48'd10;
    drive_mismatch(4'b1111, 32'h3);
    tick();
    drive_mismatch(4'b0010, 32'h4);
    tick();
    drive_clean();
    repeat (6) tick();
    chk("s3_drop", 128'(drop_count), 128'(1));
    chk("s3_mismatch", 128'(mismatch_cycles), 128'(2));
    chk("s3_first_cycle", 128'(first_cycle), 128'(10));

    // back-pressure: fill the FIFO, stall, drop, then drain in order
    clear_stats = 1'b1;
    tick();
    clear_stats = 1'b0;
    log_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cycle_number = 48'(200 + 3 * i);
      drive_mismatch(CHANNELS'(1) << (i % CHANNELS), 32'h100 + 32'(i));
      tick();
      drive_clean();
      tick(); tick();
    end
    repeat (3) tick();
    chk("s4_mismatch", 128'(mismatch_cycles), 128'(6));
    chk("s4_drop", 128'(drop_count), 128'(1));
    log_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("s4_drain_cycle", 128'(log_data[LW-1 -: 32]), 128'(200 + 3 * i));
      tick();
    end
    chk("s4_drained", 128'(log_valid), 128'(0));

    // clear_stats in the divergent cycle: not counted, still logged
    tick();
    cycle_number = 48'd300;
    drive_mismatch(4'b0100, 32'h77);
    tick();
    clear_stats = 1'b1;
    drive_clean();
    tick();
    clear_stats = 1'b0;
    chk("s5_mismatch", 128'(mismatch_cycles), 128'(0));
    chk("s5_first_valid", 128'(first_valid), 128'(0));
    tick();
    chk("s5_logged", 128'(log_data), 128'({32'd300, 8'd2, 32'h77}));
    tick(); tick();

    // reset in the middle of a scan discards everything
    log_ready = 1'b0;
    drive_mismatch(4'b1111, 32'h5);
    tick();
    drive_clean();
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("s6_valid", 128'(log_valid), 128'(0));
    chk("s6_state", 128'(dbg_state), 128'(0));
    log_ready = 1'b1;
    repeat (3) tick();

`ifdef DIVERGENCE_LOGGER_MASK_EN
    // masked channel never reports
    chan_mask = 4'b0100;
    clear_stats = 1'b1;
    tick();
    clear_stats = 1'b0;
    drive_mismatch(4'b0100, 32'h1);
    tick();
    drive_clean();
    tick(); tick();
    chk("s7_no_entry", 128'(log_valid), 128'(0));
    chk("s7_mismatch", 128'(mismatch_cycles), 128'(0));
    chan_mask = '0;
`endif

    // random traffic against the model
    for (int n = 0; n < 500; n++) begin
      log_ready   = ($urandom_range(0, 3) != 0);
      enable      = ($urandom_range(0, 15) != 0);
      clear_stats = ($urandom_range(0, 31) == 0);
      reset       = ($urandom_range(0, 127) == 0);
`ifdef DIVERGENCE_LOGGER_MASK_EN
      chan_mask   = ($urandom_range(0, 3) == 0) ? CHANNELS'($urandom) : '0;
`endif
      if ($urandom_range(0, 2) == 0)
        drive_mismatch(CHANNELS'($urandom_range(1, (1 << CHANNELS) - 1)),
                       WIDTH'($urandom_range(1, 32'h7fff_ffff)));
      else
        drive_clean();
      tick();
    end
    reset = 1'b0; clear_stats = 1'b0; log_ready = 1'b1;
    drive_clean();
    repeat (20) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
